// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the generic pipeline stage register (package pipe_pkg).
// Control-word field layout and data-lane indices used by the ID/EX, EX/MEM and MEM/WB instances.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned NUM_LANES_DEF = 8;
    localparam int unsigned CTRL_W_DEF    = 24;
    localparam int unsigned CNT_W         = 32;

    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = '0;

    // Control-word field widths (23 bits used, MSB is padding)
    localparam int unsigned REGDST_W   = 2;
    localparam int unsigned ALUOP_W    = 6;
    localparam int unsigned ALUSRC0_W  = 2;
    localparam int unsigned ALUSRC1_W  = 2;
    localparam int unsigned MUXSTORE_W = 2;
    localparam int unsigned BRANCH_W   = 1;
    localparam int unsigned MEMREAD_W  = 1;
    localparam int unsigned MEMWRITE_W = 1;
    localparam int unsigned JREG_W     = 1;
    localparam int unsigned REGWRITE_W = 1;
    localparam int unsigned MEMREG_W   = 2;
    localparam int unsigned MUXLOAD_W  = 2;

    localparam int unsigned REGDST_OFF   = 0;
    localparam int unsigned ALUOP_OFF    = REGDST_OFF   + REGDST_W;
    localparam int unsigned ALUSRC0_OFF  = ALUOP_OFF    + ALUOP_W;
    localparam int unsigned ALUSRC1_OFF  = ALUSRC0_OFF  + ALUSRC0_W;
    localparam int unsigned MUXSTORE_OFF = ALUSRC1_OFF  + ALUSRC1_W;
    localparam int unsigned BRANCH_OFF   = MUXSTORE_OFF + MUXSTORE_W;
    localparam int unsigned MEMREAD_OFF  = BRANCH_OFF   + BRANCH_W;
    localparam int unsigned MEMWRITE_OFF = MEMREAD_OFF  + MEMREAD_W;
    localparam int unsigned JREG_OFF     = MEMWRITE_OFF + MEMWRITE_W;
    localparam int unsigned REGWRITE_OFF = JREG_OFF     + JREG_W;
    localparam int unsigned MEMREG_OFF   = REGWRITE_OFF + REGWRITE_W;
    localparam int unsigned MUXLOAD_OFF  = MEMREG_OFF   + MEMREG_W;
    localparam int unsigned CTRL_USED_W  = MUXLOAD_OFF  + MUXLOAD_W;

    localparam int unsigned LANE_PC      = 0;
    localparam int unsigned LANE_RS      = 1;
    localparam int unsigned LANE_RT      = 2;
    localparam int unsigned LANE_ADDR_RS = 3;
    localparam int unsigned LANE_ADDR_RT = 4;
    localparam int unsigned LANE_RD      = 5;
    localparam int unsigned LANE_SEXT    = 6;
    localparam int unsigned LANE_ZEXT    = 7;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready bus of one pipeline stage plus its flush input.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_LANES = 8,
    parameter int unsigned CTRL_W    = 24
);
    logic                          in_valid;
    logic                          in_ready;
    logic [CTRL_W-1:0]             in_ctrl;
    logic [NUM_LANES*DATA_W-1:0]   in_data;
    logic                          flush;
    logic                          out_valid;
    logic                          out_ready;
    logic [CTRL_W-1:0]             out_ctrl;
    logic [NUM_LANES*DATA_W-1:0]   out_data;

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_reg_stats.sv
// Saturating stall/bubble/flush event counters for one pipeline stage (module pipe_stage_stats).
module pipe_stage_stats
    import pipe_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             stall_i,
    input  logic             bubble_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

    // Each counter sticks at all-ones instead of wrapping
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            stall_q  <= stall_q  + CNT_W'(stall_i  && (stall_q  != '1));
            bubble_q <= bubble_q + CNT_W'(bubble_i && (bubble_q != '1));
            flush_q  <= flush_q  + CNT_W'(flush_i  && (flush_q  != '1));
        end
    end

    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
    assign flush_cnt_o  = flush_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with 2-entry skid buffer and synchronous flush.
// Optional PIPE_STAGE_STATS_EN adds stall/bubble/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned NUM_LANES   = NUM_LANES_DEF,
    parameter int unsigned CTRL_W      = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    pipe_stage_reg_if.slave   bus
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);
    localparam int unsigned BUS_W = NUM_LANES * DATA_W;

    pipe_state_e       state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [BUS_W-1:0]  data_q, data_d, skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic              acc, deq;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= EMPTY;
            ctrl_q      <= CTRL_BUBBLE;
            data_q      <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // ctrl_q is the output control word itself, so it is loaded with the bubble on entering EMPTY
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        acc         = bus.in_valid && in_ready_q;
        deq         = (state_q != EMPTY) && bus.out_ready;

        if (bus.flush) begin
            state_d = EMPTY;
            ctrl_d  = CTRL_BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        ctrl_d  = bus.in_ctrl;
                        data_d  = bus.in_data;
                    end
                end
                ONE: begin
                    if (acc && !deq) begin
                        state_d     = TWO;
                        skid_ctrl_d = bus.in_ctrl;
                        skid_data_d = bus.in_data;
                    end else if (acc && deq) begin
                        ctrl_d = bus.in_ctrl;
                        data_d = bus.in_data;
                    end else if (deq) begin
                        state_d = EMPTY;
                        ctrl_d  = CTRL_BUBBLE;
                    end
                end
                TWO: begin
                    if (deq) begin
                        state_d = ONE;
                        ctrl_d  = skid_ctrl_q;
                        data_d  = skid_data_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    ctrl_d  = CTRL_BUBBLE;
                end
            endcase
        end

        in_ready_d = (state_d != TWO);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_ctrl  = ctrl_q;
    assign bus.out_data  = data_q;

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats u_stats (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .stall_i      ((state_q != EMPTY) && !bus.out_ready),
        .bubble_i     (state_q == EMPTY),
        .flush_i      (bus.flush),
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt),
        .flush_cnt_o  (flush_cnt)
    );
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, corner sequences and a queue-model random run.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NL = 8;
    localparam int unsigned CW = 24;
    localparam int unsigned BW = DW * NL;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    pipe_stage_reg_if #(.DATA_W(DW), .NUM_LANES(NL), .CTRL_W(CW)) bus ();

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

    pipe_stage_reg #(.DATA_W(DW), .NUM_LANES(NL), .CTRL_W(CW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [BW-1:0] data;
    } beat_t;

    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic          er;
        logic [CW-1:0] ec;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: a bounded FIFO of at most two beats
    beat_t       mq[$];
    logic        m_ready = 1'b0;
    logic [BW-1:0] m_data = '0;
    logic [31:0] m_stall = '0, m_bubble = '0, m_flush = '0;

    vec_t tq[$];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    task automatic check_model();
        logic [CW-1:0] ec;
        ec = (mq.size() != 0) ? mq[0].ctrl : CW'(0);
        chk("m_out_valid", BW'(bus.out_valid), BW'(mq.size() != 0));
        chk("m_in_ready",  BW'(bus.in_ready),  BW'(m_ready));
        chk("m_out_ctrl",  BW'(bus.out_ctrl),  BW'(ec));
        chk("m_out_data",  bus.out_data,       m_data);
`ifdef PIPE_STAGE_STATS_EN
        chk("m_stall_cnt",  BW'(stall_cnt),  BW'(m_stall));
        chk("m_bubble_cnt", BW'(bubble_cnt), BW'(m_bubble));
        chk("m_flush_cnt",  BW'(flush_cnt),  BW'(m_flush));
`endif
    endtask

    // Advance the model on the current inputs, then clock the DUT and compare
    task automatic step();
        logic  acc, deq;
        beat_t b;
        if (!Rst_n) begin
            mq.delete();
            m_ready  = 1'b0;
            m_data   = '0;
            m_stall  = '0;
            m_bubble = '0;
            m_flush  = '0;
        end else begin
            acc = bus.in_valid && m_ready;
            deq = (mq.size() != 0) && bus.out_ready;
            m_stall  = sat_inc(m_stall,  (mq.size() != 0) && !bus.out_ready);
            m_bubble = sat_inc(m_bubble, mq.size() == 0);
            m_flush  = sat_inc(m_flush,  bus.flush);
            if (bus.flush) begin
                mq.delete();
            end else begin
                if (deq) mq.delete(0);
                if (acc) begin
                    b.ctrl = bus.in_ctrl;
                    b.data = bus.in_data;
                    mq.push_back(b);
                end
            end
            m_ready = (mq.size() < 2);
            if (mq.size() != 0) m_data = mq[0].data;
        end
        @(posedge Clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_ctrl   = ic;
        bus.in_data   = {NL{8'h00, ic}};
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic add(input logic iv, input logic [CW-1:0] ic, input logic ordy, input logic fl,
                       input logic ev, input logic er, input logic [CW-1:0] ec);
        vec_t v;
        v.iv = iv; v.ic = ic; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.er = er; v.ec = ec;
        tq.push_back(v);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        drive(1'b1, 24'h5A5A5A, 1'b1, 1'b0);
        step();
        step();
        chk("rst_out_valid", BW'(bus.out_valid), BW'(0));
        chk("rst_out_ctrl",  BW'(bus.out_ctrl),  BW'(0));
        chk("rst_in_ready",  BW'(bus.in_ready),  BW'(0));
        chk("rst_out_data",  bus.out_data,       BW'(0));
        Rst_n = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk("rel_in_ready",  BW'(bus.in_ready),  BW'(1));
        chk("rel_out_valid", BW'(bus.out_valid), BW'(0));
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        do_reset();

        // Streaming, backpressure into TWO, flush in TWO and in ONE
        add(1, 24'h000001, 1, 0,  1, 1, 24'h000001);
        add(1, 24'h000002, 1, 0,  1, 1, 24'h000002);
        add(1, 24'h000003, 1, 0,  1, 1, 24'h000003);
        add(1, 24'h000004, 1, 0,  1, 1, 24'h000004);
        add(1, 24'h000005, 1, 0,  1, 1, 24'h000005);
        add(0, 24'h000000, 1, 0,  0, 1, 24'h000000);
        add(1, 24'h00000A, 0, 0,  1, 1, 24'h00000A);
        add(1, 24'h00000B, 0, 0,  1, 0, 24'h00000A);
        add(1, 24'h000077, 0, 0,  1, 0, 24'h00000A);
        add(0, 24'h000000, 1, 0,  1, 1, 24'h00000B);
        add(0, 24'h000000, 1, 0,  0, 1, 24'h000000);
        add(1, 24'h000010, 0, 0,  1, 1, 24'h000010);
        add(1, 24'h000011, 0, 0,  1, 0, 24'h000010);
        add(1, 24'h00000C, 0, 1,  0, 1, 24'h000000);
        add(1, 24'h000020, 0, 0,  1, 1, 24'h000020);
        add(1, 24'h00000C, 1, 1,  0, 1, 24'h000000);
        add(0, 24'h000000, 1, 0,  0, 1, 24'h000000);

        for (int i = 0; i < tq.size(); i++) begin
            drive(tq[i].iv, tq[i].ic, tq[i].ordy, tq[i].fl);
            step();
            chk($sformatf("vec%0d_valid", i), BW'(bus.out_valid), BW'(tq[i].ev));
            chk($sformatf("vec%0d_ready", i), BW'(bus.in_ready),  BW'(tq[i].er));
            chk($sformatf("vec%0d_ctrl", i),  BW'(bus.out_ctrl),  BW'(tq[i].ec));
        end

        // Lane mapping: lane 3 lands at bits [127:96]
        bus.in_valid  = 1'b1;
        bus.in_ctrl   = 24'h000033;
        bus.in_data   = '0;
        bus.in_data[3*DW +: DW] = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        step();
        chk("lane3_slice", BW'(bus.out_data[127:96]), BW'(32'hDEADBEEF));
        chk("lane3_full",  bus.out_data, BW'(32'hDEADBEEF) << 96);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk("lane3_hold", bus.out_data, BW'(32'hDEADBEEF) << 96);

        // Counter sequence from a fresh reset: 3 idle, accept, 4 stalls, flush with deq, 1 idle
        do_reset();
        for (int i = 0; i < 3; i++) step();
        drive(1'b1, 24'h000042, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        drive(1'b0, '0, 1'b1, 1'b1);
        step();
        chk("flush_out_valid", BW'(bus.out_valid), BW'(0));
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
`ifdef PIPE_STAGE_STATS_EN
        chk("seq_stall_cnt",  BW'(stall_cnt),  BW'(4));
        chk("seq_flush_cnt",  BW'(flush_cnt),  BW'(1));
        chk("seq_bubble_cnt", BW'(bubble_cnt), BW'(6));
`endif

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 2000; i++) begin
            Rst_n         = ($urandom_range(0, 99) != 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_ctrl   = CW'($urandom);
            for (int k = 0; k < NL; k++) bus.in_data[k*DW +: DW] = $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
